// File: rtl/cnn_argmax_classifier.sv
// Argmax classifier: captures a packed score vector, scans one class per cycle and
// reports winning index, winning score, top-1/top-2 margin and a confidence flag.
module cnn_argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 113,
    parameter int IDX_W       = 4,
    parameter int SIGNED      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    input  logic [SCORE_W:0]               margin_thresh,
    output logic                           busy,
    output logic                           done,
    output logic [IDX_W-1:0]               result,
    output logic [SCORE_W-1:0]             max_score,
    output logic [SCORE_W:0]               margin,
    output logic                           confident,
    output logic [1:0]                     dbg_state
);

    // Handshake: enable is a start strobe accepted only in IDLE (no backpressure);
    // done is a one-cycle strobe, and the result outputs hold until the next done.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [SCORE_W-1:0] MIN_SCORE = (SIGNED != 0) ? {1'b1, {(SCORE_W-1){1'b0}}}
                                                             : {SCORE_W{1'b0}};

    state_t state;
    state_t state_nxt;

    logic [NUM_CLASSES*SCORE_W-1:0] score_q;
    logic [SCORE_W:0]               thresh_q;
    logic [SCORE_W-1:0]             best;
    logic [SCORE_W-1:0]             second;
    logic [IDX_W-1:0]               best_idx;
    logic [IDX_W-1:0]               idx;

    logic                           at_last;
    logic [SCORE_W-1:0]             cur_score;
    logic [SCORE_W:0]               margin_c;
    logic                           start;
    logic                           scan_step;
    logic                           finish;

    function automatic logic gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // One extra bit keeps best - second exact for the full signed range.
    function automatic logic [SCORE_W:0] ext(input logic [SCORE_W-1:0] a);
        return {((SIGNED != 0) ? a[SCORE_W-1] : 1'b0), a};
    endfunction

    assign at_last = (idx == LAST_IDX);

    always_comb begin
        cur_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_score = score_q[k*SCORE_W +: SCORE_W];
            end
        end
    end

    assign margin_c = ext(best) - ext(second);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable) state_nxt = S_SCAN;
            S_SCAN:  if (at_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start     = (state == S_IDLE) && enable;
        scan_step = (state == S_SCAN);
        finish    = (state == S_DONE);
        busy      = (state == S_SCAN) || (state == S_DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            score_q  <= '0;
            thresh_q <= '0;
            best     <= '0;
            second   <= '0;
            best_idx <= '0;
            idx      <= '0;
        end else if (start) begin
            score_q  <= scores;
            thresh_q <= margin_thresh;
            best     <= scores[SCORE_W-1:0];
            second   <= MIN_SCORE;
            best_idx <= '0;
            idx      <= IDX_W'(1);
        end else if (scan_step) begin
            // Strict compares: the lowest index keeps a tie and the equal score drops to second.
            if (gt(cur_score, best)) begin
                second   <= best;
                best     <= cur_score;
                best_idx <= idx;
            end else if (gt(cur_score, second)) begin
                second <= cur_score;
            end
            idx <= idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done      <= 1'b0;
            result    <= '0;
            max_score <= '0;
            margin    <= '0;
            confident <= 1'b0;
        end else if (finish) begin
            done      <= 1'b1;
            result    <= best_idx;
            max_score <= best;
            margin    <= margin_c;
            confident <= (margin_c > thresh_q);
        end else begin
            done <= 1'b0;
        end
    end

endmodule
